dtmf_tone_sequencer: RTL and testbench
======================================

Name: dtmf_tone_sequencer

Overview:
Accepts one 4-bit keypad code per transaction and produces the matching DTMF tone pair. The row and column square waves come from internal half-period counters clocked at the 1 MHz system clock; the column divisors match the team's standalone stepdown dividers (1477 Hz uses 339). The tone is held for a fixed duration, then a silent inter-digit gap follows. Feeds the 2-bit summing DAC / speaker driver stage of the DTMF path.

Parameters:
CLK_HZ, 1000000, input clock frequency; sets the ms tick divisor CLK_HZ/1000.
TONE_MS, 100, tone-on duration in milliseconds.
GAP_MS, 50, silent gap after each tone in milliseconds.

Ports:
inclk  input  1  system clock, 1 MHz nominal; sole clock.
reset_n  input  1  synchronous active-low reset, sampled on posedge inclk.
key_code  input  4  key code: [3:2] = row index, [1:0] = column index.
key_valid  input  1  key_code is valid.
key_ready  output  1  block can accept a key; high only in IDLE.
row_tone  output  1  row-frequency square wave.
col_tone  output  1  column-frequency square wave.
dtmf_out  output  2  row_tone + col_tone (0..2), unsigned.
tone_active  output  1  high during TONE state.

Behaviour:
- Reset (reset_n low at posedge): state=IDLE, key_ready=1, row_tone=0, col_tone=0, dtmf_out=0, tone_active=0, all counters=0. Reset overrides every other condition, including mid-TONE and mid-GAP.
- Key map: row index 0..3 maps to keys 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D. Code 13 = '0', 12 = '*', 14 = '#'.
- Row half-period divisors, in cycles:
  - 697 Hz: 717
  - 770 Hz: 649
  - 852 Hz: 587
  - 941 Hz: 531
- Column half-period divisors, in cycles:
  - 1209 Hz: 414
  - 1336 Hz: 374
  - 1477 Hz: 339
  - 1633 Hz: 306
- Divisors are latched at accept. key_code changes after accept have no effect.
- Handshake: accept when key_valid && key_ready on a posedge. key_valid while key_ready=0 is ignored and is not queued.
- FSM states:
  - IDLE: on accept -> TONE.
  - TONE: on expiry of TONE_MS*CLK_HZ/1000 cycles -> GAP.
  - GAP: on expiry of GAP_MS*CLK_HZ/1000 cycles -> IDLE.
- Timing: the accept edge is cycle 0. tone_active=1 and key_ready=0 from cycle 1. tone_active stays high for exactly TONE_MS*1000 cycles at the default CLK_HZ.
- Then GAP for exactly GAP_MS*1000 cycles:
  - tone_active=0, tone outputs forced 0, key_ready=0.
  - key_ready=1 on the cycle after GAP ends.
- Tone generation: each half-period counter restarts at 0 on accept and both tones start at 0. Each cycle in TONE:
  - the counter increments;
  - when it equals its divisor, the tone toggles and the counter clears.
  - The first toggle is therefore `div` cycles after TONE entry.
- Row and column counters are independent; simultaneous toggles are allowed.
- Duration timing: an ms prescaler counts 0..CLK_HZ/1000-1 and emits a tick. A ms counter counts ticks against TONE_MS or GAP_MS and clears on every state change.
- Outputs are registered. dtmf_out is computed from the registered tones in the same cycle (no extra latency).
- A TONE_MS or GAP_MS of 0 is treated as 1 ms.
- Leaving TONE always forces both tones low on GAP entry, regardless of phase.

Test Plan:
- Reset then idle: reset_n low 2 cycles, then high -> key_ready=1, dtmf_out=0, tone_active=0 held indefinitely with key_valid=0.
- Key '9' (code 10), TONE_MS=2, GAP_MS=1 -> tone_active high exactly 2000 cycles; row_tone toggles every 587 cycles; col_tone toggles every 339 cycles; key_ready rises 3001 cycles after accept.
- Key 'D' (code 15) -> row period 1062 cycles, col period 612 cycles. dtmf_out equals 2 exactly when both tones are high, checked every cycle.
- Busy rejection: pulse key_valid with code 0 during TONE and during GAP -> ignored; after GAP, no second tone starts without a new key_valid.
- Reset mid-tone: assert reset_n low 500 cycles into TONE -> next posedge gives all outputs 0 and key_ready=1; a new key accepted afterward produces a correct full-length tone.
- Back-to-back: hold key_valid high with codes 0 then 13 -> two tones separated by a 1000-cycle silent gap; second tone is 941 Hz / 1336 Hz (divisors 531 / 374).

Source files
------------

// File: rtl/dtmf_tone_sequencer.sv
// dtmf_tone_sequencer: one keypad code per handshake -> timed DTMF row/column square-wave pair, then a silent gap.
// Ports: inclk (1 MHz clock), reset_n (sync active-low reset), key_code[3:2]=row / [1:0]=col,
// key_valid/key_ready (accept handshake, ready only in IDLE), row_tone/col_tone (square waves),
// dtmf_out = row_tone + col_tone, tone_active (high in TONE).
module dtmf_tone_sequencer #(
  parameter int CLK_HZ  = 1000000,
  parameter int TONE_MS = 100,
  parameter int GAP_MS  = 50
) (
  input  logic       inclk,
  input  logic       reset_n,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       row_tone,
  output logic       col_tone,
  output logic [1:0] dtmf_out,
  output logic       tone_active
);
  localparam int PRE  = (CLK_HZ / 1000) < 1 ? 1 : CLK_HZ / 1000;
  localparam int PW   = PRE > 1 ? $clog2(PRE) : 1;
  // Zero-length durations are stretched to 1 ms.
  localparam int TLIM = TONE_MS < 1 ? 1 : TONE_MS;
  localparam int GLIM = GAP_MS < 1 ? 1 : GAP_MS;
  localparam int MW   = $clog2((TLIM > GLIM ? TLIM : GLIM) + 1);
  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;
  state_t state, next;
  logic [PW-1:0] pre;
  logic [MW-1:0] ms;
  logic [9:0] row_div, col_div, row_cnt, col_cnt;
  logic accept, tick, expire;
  function automatic logic [9:0] row_div_of(input logic [1:0] r);
    return r == 2'd0 ? 10'd717 : r == 2'd1 ? 10'd649 : r == 2'd2 ? 10'd587 : 10'd531;
  endfunction
  function automatic logic [9:0] col_div_of(input logic [1:0] c);
    return c == 2'd0 ? 10'd414 : c == 2'd1 ? 10'd374 : c == 2'd2 ? 10'd339 : 10'd306;
  endfunction
  assign accept = key_valid && key_ready;
  assign tick   = pre == PW'(PRE - 1);
  assign expire = tick && (ms == (state == TONE ? MW'(TLIM - 1) : MW'(GLIM - 1)));
  always_ff @(posedge inclk)
    if (!reset_n) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE ? (accept ? TONE : IDLE) :
           state == TONE ? (expire ? GAP  : TONE) :
           state == GAP  ? (expire ? IDLE : GAP)  : IDLE;
  always_comb begin
    key_ready   = state == IDLE;
    tone_active = state == TONE;
    dtmf_out    = {1'b0, row_tone} + {1'b0, col_tone};
  end
  // Duration timing restarts from zero on every state change.
  always_ff @(posedge inclk)
    if (!reset_n || state != next || state == IDLE) begin
      pre <= '0;
      ms  <= '0;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      ms  <= tick ? ms + MW'(1) : ms;
    end
  always_ff @(posedge inclk)
    if (!reset_n) begin
      row_div  <= '0;
      col_div  <= '0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      row_tone <= 1'b0;
      col_tone <= 1'b0;
    end else if (accept) begin
      row_div  <= row_div_of(key_code[3:2]);
      col_div  <= col_div_of(key_code[1:0]);
      row_cnt  <= '0;
      col_cnt  <= '0;
      row_tone <= 1'b0;
      col_tone <= 1'b0;
    end else if (state == TONE && !expire) begin
      row_cnt  <= row_cnt == row_div - 10'd1 ? 10'd0 : row_cnt + 10'd1;
      col_cnt  <= col_cnt == col_div - 10'd1 ? 10'd0 : col_cnt + 10'd1;
      row_tone <= row_cnt == row_div - 10'd1 ? ~row_tone : row_tone;
      col_tone <= col_cnt == col_div - 10'd1 ? ~col_tone : col_tone;
    end else begin
      // Leaving TONE (and all of GAP/IDLE) holds both tones low.
      row_cnt  <= '0;
      col_cnt  <= '0;
      row_tone <= 1'b0;
      col_tone <= 1'b0;
    end
endmodule

// File: tb/tb_dtmf_tone_sequencer.sv
// tb_dtmf_tone_sequencer: scoreboard bench; stimulus queues expected bursts, a monitor measures each tone/gap burst.
module tb_dtmf_tone_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic key_valid = 1'b0;
  logic key_ready, row_tone, col_tone, tone_active;
  logic [1:0] dtmf_out;
  int total = 0;
  int bad = 0;
  typedef struct {int rdiv; int cdiv; int tlen; int glen; bit abort;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  dtmf_tone_sequencer #(.CLK_HZ(1000000), .TONE_MS(2), .GAP_MS(1)) dut (
    .inclk(clk), .reset_n(rst_n), .key_code(key_code), .key_valid(key_valid),
    .key_ready(key_ready), .row_tone(row_tone), .col_tone(col_tone),
    .dtmf_out(dtmf_out), .tone_active(tone_active)
  );
  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask
  task automatic send(input logic [3:0] c, input int rd, input int cd, input bit ab);
    int n = 0;
    @(negedge clk);
    while (!key_ready && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (!key_ready) chk("send_ready", 0, 1);
    key_code = c;
    key_valid = 1'b1;
    sb.push_back('{rd, cd, 2000, 1000, ab});
    @(negedge clk);
    key_valid = 1'b0;
  endtask
  task automatic pulse_busy();
    @(negedge clk);
    key_code = 4'd0;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (tone_active) begin
        exp_t e;
        int tcnt, gcnt, gbad, dbad, rfirst, cfirst, rlast, clast, rbad, cbad;
        logic pr, pc;
        e = '{0, 0, 2000, 1000, 1'b0};
        if (sb.size() == 0) chk("unexpected_tone", 1, 0);
        else e = sb.pop_front();
        tcnt = 0; gcnt = 0; gbad = 0; dbad = 0; rbad = 0; cbad = 0;
        rfirst = -1; cfirst = -1; rlast = 0; clast = 0; pr = 1'b0; pc = 1'b0;
        while (tone_active && tcnt < 5000) begin
          tcnt++;
          if (row_tone != pr) begin
            if (rfirst < 0) rfirst = tcnt;
            else if (tcnt - rlast != e.rdiv) rbad++;
            rlast = tcnt;
            pr = row_tone;
          end
          if (col_tone != pc) begin
            if (cfirst < 0) cfirst = tcnt;
            else if (tcnt - clast != e.cdiv) cbad++;
            clast = tcnt;
            pc = col_tone;
          end
          if (int'(dtmf_out) != int'(row_tone) + int'(col_tone) || key_ready) dbad++;
          @(negedge clk);
        end
        chk("dtmf_sum_busy", dbad, 0);
        if (e.abort) begin
          chk("abort_early", int'(tcnt < e.tlen), 1);
          chk("abort_outputs", int'({key_ready, tone_active, row_tone, col_tone, dtmf_out}), 32);
        end else begin
          chk("tone_len", tcnt, e.tlen);
          chk("row_first", rfirst, e.rdiv + 1);
          chk("col_first", cfirst, e.cdiv + 1);
          chk("row_period", rbad, 0);
          chk("col_period", cbad, 0);
          while (!key_ready && gcnt < 5000) begin
            gcnt++;
            if (row_tone || col_tone || tone_active || dtmf_out != 2'd0) gbad++;
            @(negedge clk);
          end
          chk("gap_len", gcnt, e.glen);
          chk("gap_silent", gbad, 0);
        end
      end
    end
  end
  initial begin : stim
    int viol, n;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", int'(key_ready), 1);
    chk("rst_dtmf", int'(dtmf_out), 0);
    chk("rst_active", int'(tone_active), 0);
    viol = 0;
    repeat (200) begin
      @(negedge clk);
      if (!key_ready || tone_active || dtmf_out != 2'd0) viol++;
    end
    chk("idle_hold", viol, 0);
    send(4'd10, 587, 339, 1'b0);
    repeat (3100) @(negedge clk);
    send(4'd15, 531, 306, 1'b0);
    repeat (3100) @(negedge clk);
    send(4'd6, 649, 339, 1'b0);
    repeat (500) @(negedge clk);
    pulse_busy();
    repeat (2000) @(negedge clk);
    pulse_busy();
    repeat (4000) @(negedge clk);
    chk("no_requeue", int'(tone_active), 0);
    send(4'd10, 587, 339, 1'b1);
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(4'd5, 649, 374, 1'b0);
    repeat (3100) @(negedge clk);
    @(negedge clk);
    key_code = 4'd0;
    key_valid = 1'b1;
    sb.push_back('{717, 414, 2000, 1000, 1'b0});
    @(negedge clk);
    key_code = 4'd13;
    sb.push_back('{531, 374, 2000, 1000, 1'b0});
    n = 0;
    while (!key_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_ready", int'(key_ready), 1);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (3500) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("end_ready", int'(key_ready), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
